// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by a 16x oversample strobe. Validates the start bit,
// samples each bit at mid-period, checks the stop bit and hands bytes out on valid/ready.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic                 armed;
  logic                 rx_meta;
  logic                 rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Handshake: a byte transfers on any clk edge where rx_valid and rx_ready are both high;
  // rx_valid then drops unless a new byte is delivered on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rx_en) begin
        case (state)
          IDLE: begin
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
              tcnt  <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (tcnt == T_HALF) begin
              if (!rxs) begin
                state <= DATA;
                tcnt  <= '0;
                bcnt  <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DATA: begin
            if (tcnt == T_LAST) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              tcnt  <= '0;
              if (bcnt == B_LAST) state <= STOP;
              else bcnt <= bcnt + 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          STOP: begin
            if (tcnt == T_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              tcnt  <= '0;
              if (rxs) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                // A held-low line (break) must return high before a new start counts.
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for asynchronous 8N1 frames on one RX line, driven by the 16x-oversample enable strobe from the baud rate generator. Detects and validates the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte on a valid/ready output port. Sits between the RX pin and the host-side consumer; it is the receiving counterpart of the UART transmit path.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first; no parity.
- OVERSAMPLE, 16, rx_en strobes per bit period; must be even and ≥4.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clock clk.
- rx_en  input  1  one-clk strobe at OVERSAMPLE x baud; all bit timing advances only on clk edges where rx_en=1.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  DATA_BITS  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts byte on a clk edge with rx_valid=1 and rx_ready=1.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: frame completed while rx_valid=1 and not accepted that edge.
- busy  output  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxs.
- Tick counter tcnt (width clog2(OVERSAMPLE)) and bit counter bcnt (width clog2(DATA_BITS)) advance only on rx_en.
- States: IDLE, START, DATA, STOP.
- IDLE: armed flag set whenever rxs=1 on an rx_en tick. On an rx_en tick with rxs=0 and armed=1: go START, tcnt=0.
- START: tcnt increments each tick; at tcnt=OVERSAMPLE/2-1, sample rxs: 0 -> DATA, tcnt=0, bcnt=0; 1 -> false start, back to IDLE, nothing reported.
- DATA: at tcnt=OVERSAMPLE-1, shift rxs into shift register MSB (right shift, so first bit ends at LSB), tcnt=0; after bcnt=DATA_BITS-1 sample -> STOP, else bcnt+1.
- STOP: at tcnt=OVERSAMPLE-1 sample rxs. 1 -> frame good, deliver byte; 0 -> frame_err pulse, byte discarded, armed cleared (a break does not re-trigger until line returns high). Either way -> IDLE.
- Delivery on good frame: if rx_valid=0, or rx_valid=1 and rx_ready=1 on the same edge: rx_data <= shift register, rx_valid=1. If rx_valid=1 and rx_ready=0: overrun pulse, new byte dropped, rx_data/rx_valid unchanged.
- Accept without new delivery: rx_valid=1 and rx_ready=1 -> rx_valid=0 next edge; rx_data keeps last value.
- rx_ready with rx_valid=0 has no effect.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0; state IDLE, armed=0, synchronizer=1, counters=0.
- Reset mid-frame aborts the frame immediately; no partial byte, no error pulse.
- Start detection latency: 2 clk synchronizer + up to one rx_en period.
- Samples fall OVERSAMPLE/2 ticks (±1 tick detection jitter) after each bit edge.
- rx_valid rises on the clk edge of the rx_en tick that samples the stop bit (mid stop bit); frame_err/overrun pulse on that same edge for exactly one clk.
- Next start bit is detectable from the following rx_en tick, so back-to-back frames with one stop bit are received without loss.
- No combinational path from rx_ready to rx_valid.

## Test plan
- Clock 50 MHz, rx_en every 326 clk, send 0xA5 at 9600 baud, rx_ready=1 -> rx_data=0xA5, rx_valid high one clk, frame_err=0, overrun=0, busy low after stop sample.
- Low glitch on rx for 4 rx_en ticks in IDLE -> no rx_valid, busy returns low by tick 8, following frame 0x3C received correctly.
- Frame 0x55 with stop bit driven low, rx held low 2 bit times after -> one frame_err pulse, no rx_valid, no start detected until rx returns high; next frame 0x0F received.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulses at 0x22 stop sample; raise rx_ready -> rx_valid drops next edge.
- rx_valid=1 with 0x11, assert rx_ready exactly on 0x22 stop-sample edge -> rx_data=0x22, rx_valid stays 1, no overrun.
- Assert reset during bit 4 of a frame -> all outputs at reset values next edge; after release, complete frame 0xC3 received correctly.
